prog_loader: RTL and testbench

Byte-stream program loader that writes the two instruction memories, opcode memory and operand memory, which the stack core fetches from. It holds the core in reset while a framed program arrives over a valid/ready byte link. It validates length and checksum, and releases the core only after a good frame. It writes on posedge `clk`; the instruction memories sample on the inverted clock, so write address and data are stable at the sampling edge.

---
 rtl/prog_loader.sv | 119 +++++++++++
 tb/tb_prog_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for the opcode/operand instruction memories.
// Ports: clk, rst (async active-low); rx_valid/rx_data/rx_ready byte link;
// wr_en/wr_addr/wr_op/wr_arg memory write port; core_rst (low holds core);
// done/err levels and err_code (1 length, 2 checksum, 3 timeout).
module prog_loader #(
    parameter int                  addrwide = 8,
    parameter int                  datawide = 8,
    parameter int                  stop_pc  = 250,
    parameter logic [datawide-1:0] HEADER   = 8'hA5,
    parameter int                  TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [datawide-1:0] rx_data,
    output logic                rx_ready,
    output logic                wr_en,
    output logic [addrwide-1:0] wr_addr,
    output logic [datawide-1:0] wr_op,
    output logic [datawide-1:0] wr_arg,
    output logic                core_rst,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    typedef enum logic [2:0] {IDLE, LEN, OP, ARG, CSUM, RUN, ERR} state_t;
    state_t state, state_n;
    logic [datawide-1:0] len, cnt, sum, op_q, sum_nx, cnt_nx;
    logic [15:0] tcnt;
    logic xfer, framing, expire, len_bad, hdr;
    // the write cycle is the only bubble on the link
    assign rx_ready = !wr_en;
    assign xfer     = rx_valid && rx_ready;
    assign framing  = state inside {LEN, OP, ARG, CSUM};
    // a transfer in the expiring cycle wins over the timeout
    assign expire   = framing && !xfer && tcnt == 16'(TIMEOUT - 1);
    assign sum_nx   = sum + rx_data;
    assign cnt_nx   = cnt + datawide'(1);
    assign len_bad  = rx_data == '0 || rx_data > datawide'(stop_pc);
    assign hdr      = rx_data == HEADER;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (expire) state_n = ERR;
        else if (xfer)
            case (state)
                LEN:     state_n = len_bad ? ERR : OP;
                OP:      state_n = ARG;
                ARG:     state_n = cnt_nx == len ? CSUM : OP;
                CSUM:    state_n = sum_nx == '0 ? RUN : ERR;
                default: state_n = hdr ? LEN : state;
            endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_op    <= '0;
            wr_arg   <= '0;
            core_rst <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            len      <= '0;
            cnt      <= '0;
            sum      <= '0;
            op_q     <= '0;
            tcnt     <= '0;
        end else begin
            wr_en <= 1'b0;
            tcnt  <= (framing && !xfer) ? tcnt + 16'd1 : 16'd0;
            if (expire) begin
                err      <= 1'b1;
                err_code <= 2'd3;
            end else if (xfer)
                case (state)
                    LEN:
                        if (len_bad) begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end else begin
                            len <= rx_data;
                            cnt <= '0;
                            sum <= rx_data;
                        end
                    OP: begin
                        op_q <= rx_data;
                        sum  <= sum_nx;
                    end
                    ARG: begin
                        sum     <= sum_nx;
                        wr_en   <= 1'b1;
                        wr_addr <= addrwide'(cnt);
                        wr_op   <= op_q;
                        wr_arg  <= rx_data;
                        cnt     <= cnt_nx;
                    end
                    CSUM:
                        if (sum_nx == '0) begin
                            done     <= 1'b1;
                            core_rst <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end
                    default:
                        if (hdr) begin
                            core_rst <= 1'b0;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            err_code <= 2'd0;
                        end
                endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
module tb_prog_loader;
    localparam int TIMEOUT = 1000;
    logic clk = 0, rst = 0, rx_valid = 0;
    logic [7:0] rx_data = 0;
    logic rx_ready, wr_en, core_rst, done, err;
    logic [7:0] wr_addr, wr_op, wr_arg;
    logic [1:0] err_code;
    int checks = 0, failures = 0, wcount = 0, max_gap = 0, stall_first = 0;
    logic [7:0] f_op[256], f_arg[256];

    prog_loader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op), .wr_arg(wr_arg),
        .core_rst(core_rst), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (wr_en === 1'b1) wcount++;

    // Called at posedge+1; returns at posedge+1 right after the byte transferred.
    task automatic send(input logic [7:0] b);
        bit ok = 0;
        if (max_gap > 0) begin
            rx_valid = 0;
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #1;
        end
        rx_valid = 1;
        rx_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send: rx_ready=%b for 20 cycles, required 1", rx_ready);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            f_op[i]  = 8'($urandom);
            f_arg[i] = 8'($urandom);
        end
    endtask

    // Sends LEN, n pairs and a checksum offset by delta from the correct value.
    task automatic body(input int n, input logic [7:0] delta);
        logic [7:0] s, c;
        int base;
        bit good;
        base = wcount;
        s = n[7:0];
        send(n[7:0]);
        for (int i = 0; i < n; i++) begin
            send(f_op[i]);
            if (i == 0 && stall_first > 0) begin
                rx_valid = 0;
                repeat (stall_first) @(posedge clk);
                #1;
            end
            send(f_arg[i]);
            s = s + f_op[i] + f_arg[i];
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== i[7:0] || wr_op !== f_op[i] || wr_arg !== f_arg[i]) begin
                failures++;
                $display("FAIL write%0d: got en=%b a=%h op=%h arg=%h, required en=1 a=%h op=%h arg=%h",
                         i, wr_en, wr_addr, wr_op, wr_arg, i[7:0], f_op[i], f_arg[i]);
            end
        end
        checks++;
        if (done !== 1'b0 || core_rst !== 1'b0) begin
            failures++;
            $display("FAIL early_done: got done=%b core_rst=%b, required 0 0", done, core_rst);
        end
        c = 8'h00 - s + delta;
        send(c);
        rx_valid = 0;
        good = (delta == 8'h00);
        checks++;
        if (done !== good || core_rst !== good || err !== !good || err_code !== (good ? 2'd0 : 2'd2)) begin
            failures++;
            $display("FAIL status n=%0d: got done=%b core_rst=%b err=%b code=%0d, required %b %b %b %0d",
                     n, done, core_rst, err, err_code, good, good, !good, good ? 0 : 2);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wcount - base != n) begin
            failures++;
            $display("FAIL write_count n=%0d: got %0d, required %0d", n, wcount - base, n);
        end
    endtask

    task automatic frame(input int n, input logic [7:0] delta);
        send(8'hA5);
        body(n, delta);
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, wr_en, wr_addr, wr_op, wr_arg, core_rst, done, err, err_code} !== {2'b10, 24'h0, 5'b0}) begin
            failures++;
            $display("FAIL reset: got rdy=%b en=%b a=%h op=%h arg=%h crst=%b done=%b err=%b code=%0d, required 1 0 0 0 0 0 0 0 0",
                     rx_ready, wr_en, wr_addr, wr_op, wr_arg, core_rst, done, err, err_code);
        end
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame;
        f_op[0] = 8'h01; f_arg[0] = 8'h05;
        f_op[1] = 8'h01; f_arg[1] = 8'h00;
        f_op[2] = 8'h17; f_arg[2] = 8'h00;
        frame(3, 8'h00);
    endtask

    task automatic test_bad_csum;
        f_op[0] = 8'h01; f_arg[0] = 8'h05;
        f_op[1] = 8'h01; f_arg[1] = 8'h00;
        f_op[2] = 8'h17; f_arg[2] = 8'h00;
        frame(3, 8'h01);
    endtask

    task automatic test_bad_length;
        logic [7:0] lens[3];
        int base;
        lens[0] = 8'h00;
        lens[1] = 8'hFB;
        lens[2] = 8'($urandom_range(251, 255));
        for (int k = 0; k < 3; k++) begin
            base = wcount;
            send(8'hA5);
            send(lens[k]);
            rx_valid = 0;
            checks++;
            if (err !== 1'b1 || err_code !== 2'd1 || done !== 1'b0 || core_rst !== 1'b0) begin
                failures++;
                $display("FAIL bad_len %h: got err=%b code=%0d done=%b crst=%b, required 1 1 0 0",
                         lens[k], err, err_code, done, core_rst);
            end
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (wcount != base) begin
                failures++;
                $display("FAIL bad_len_writes %h: got %0d writes, required 0", lens[k], wcount - base);
            end
        end
    endtask

    task automatic test_max_length;
        fill_random(250);
        frame(250, 8'h00);
    endtask

    task automatic test_timeout;
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        rx_valid = 0;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got err=%b, required 0", err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || core_rst !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL timeout: got err=%b code=%0d crst=%b done=%b, required 1 3 0 0", err, err_code, core_rst, done);
        end
        fill_random(2);
        stall_first = TIMEOUT - 1;
        frame(2, 8'h00);
        stall_first = 0;
    endtask

    task automatic test_noise_reload;
        int base;
        base = wcount;
        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        rx_valid = 0;
        checks++;
        if (err !== 1'b0 || wcount != base) begin
            failures++;
            $display("FAIL noise: got err=%b writes=%0d, required 0 0", err, wcount - base);
        end
        fill_random(5);
        frame(5, 8'h00);
        send(8'hA5);
        rx_valid = 0;
        checks++;
        if (core_rst !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reload_run: got crst=%b done=%b, required 0 0", core_rst, done);
        end
        fill_random(4);
        body(4, 8'h00);
        frame(2, 8'h7E);
        send(8'hA5);
        rx_valid = 0;
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL reload_err: got err=%b code=%0d, required 0 0", err, err_code);
        end
        fill_random(3);
        body(3, 8'h00);
    endtask

    task automatic test_midframe_reset;
        fill_random(2);
        send(8'hA5);
        send(8'h02);
        send(f_op[0]);
        send(f_arg[0]);
        send(f_op[1]);
        rx_valid = 0;
        #2;
        rst = 0;
        #1;
        checks++;
        if ({rx_ready, wr_en, wr_addr, wr_op, wr_arg, core_rst, done, err, err_code} !== {2'b10, 24'h0, 5'b0}) begin
            failures++;
            $display("FAIL mid_reset: got rdy=%b en=%b a=%h op=%h arg=%h crst=%b done=%b err=%b code=%0d, required 1 0 0 0 0 0 0 0 0",
                     rx_ready, wr_en, wr_addr, wr_op, wr_arg, core_rst, done, err, err_code);
        end
        @(posedge clk);
        #1;
        rst = 1;
        fill_random(6);
        frame(6, 8'h00);
    endtask

    task automatic test_random;
        int n;
        logic [7:0] delta;
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(1, 24);
            fill_random(n);
            delta = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            max_gap = $urandom_range(0, 3);
            frame(n, delta);
        end
        max_gap = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_good_frame;
        test_bad_csum;
        test_bad_length;
        test_max_length;
        test_timeout;
        test_noise_reload;
        test_midframe_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
